// File: rtl/iguana_hyper_cfg_seq.sv
// Boot-time HyperBus register configuration sequencer: waits a power-up delay, replays a fixed
// write table downstream, then hands the reg bus over to the SoC as a zero-latency pass-through.
module iguana_hyper_cfg_seq #(
    parameter int unsigned NumWrites     = 4,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter logic [NumWrites-1:0][AddrWidth-1:0] CfgAddr = '0,
    parameter logic [NumWrites-1:0][DataWidth-1:0] CfgData = '0,
    parameter int unsigned DelayCycles   = 16,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   restart_i,
    input  logic                   up_valid_i,
    input  logic                   up_write_i,
    input  logic [AddrWidth-1:0]   up_addr_i,
    input  logic [DataWidth-1:0]   up_wdata_i,
    input  logic [DataWidth/8-1:0] up_wstrb_i,
    output logic                   up_ready_o,
    output logic [DataWidth-1:0]   up_rdata_o,
    output logic                   up_error_o,
    output logic                   dn_valid_o,
    output logic                   dn_write_o,
    output logic [AddrWidth-1:0]   dn_addr_o,
    output logic [DataWidth-1:0]   dn_wdata_o,
    output logic [DataWidth/8-1:0] dn_wstrb_o,
    input  logic                   dn_ready_i,
    input  logic [DataWidth-1:0]   dn_rdata_i,
    input  logic                   dn_error_i,
    output logic                   cfg_done_o,
    output logic                   cfg_err_o
);

    localparam int unsigned CntMax = (DelayCycles > TimeoutCycles) ? DelayCycles : TimeoutCycles;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;
    localparam int unsigned IdxW   = (NumWrites > 1) ? $clog2(NumWrites) : 1;
    localparam int unsigned StrbW  = DataWidth / 8;

    localparam logic [CntW-1:0] DlyLast = CntW'(DelayCycles - 1);
    // Last valid cycle of a table write; ready not seen here means timeout.
    localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 2);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumWrites - 1);

    typedef enum logic [1:0] {StWait, StWrite, StGap, StPass} state_e;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [IdxW-1:0] r_idx, w_idx_d;
    logic            r_err, w_err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StWait;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_err   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_idx_d    = r_idx;
        w_err_d    = r_err;
        dn_valid_o = 1'b0;
        dn_write_o = 1'b0;
        dn_addr_o  = '0;
        dn_wdata_o = '0;
        dn_wstrb_o = '0;
        up_ready_o = 1'b0;
        up_rdata_o = '0;
        up_error_o = 1'b0;

        unique case (r_state)
            StWait: begin
                if (r_cnt == DlyLast) begin
                    w_state_d = StWrite;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StWrite: begin
                dn_valid_o = 1'b1;
                dn_write_o = 1'b1;
                dn_addr_o  = CfgAddr[r_idx];
                dn_wdata_o = CfgData[r_idx];
                dn_wstrb_o = {StrbW{1'b1}};
                if (dn_ready_i) begin
                    w_err_d = r_err | dn_error_i;
                    w_cnt_d = '0;
                    if (r_idx == IdxLast) begin
                        w_state_d = StPass;
                    end else begin
                        w_idx_d = r_idx + IdxW'(1);
                    end
                end else if (r_cnt == TmoLast) begin
                    w_err_d   = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StGap;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StGap: begin
                if (r_idx == IdxLast) begin
                    w_state_d = StPass;
                end else begin
                    w_idx_d   = r_idx + IdxW'(1);
                    w_state_d = StWrite;
                end
            end
            StPass: begin
                dn_valid_o = up_valid_i;
                dn_write_o = up_write_i;
                dn_addr_o  = up_addr_i;
                dn_wdata_o = up_wdata_i;
                dn_wstrb_o = up_wstrb_i;
                up_ready_o = dn_ready_i;
                up_rdata_o = dn_rdata_i;
                up_error_o = dn_error_i;
                // A pending SoC transfer always beats a restart request.
                if (restart_i && !up_valid_i) begin
                    w_state_d = StWait;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                end
            end
            default: begin
                w_state_d = StWait;
            end
        endcase
    end

    assign cfg_done_o = (r_state == StPass);
    assign cfg_err_o  = r_err;

endmodule

// File: tb/tb_iguana_hyper_cfg_seq.sv
// Self-checking bench for iguana_hyper_cfg_seq: directed table/stall/error/timeout/reset cases
// plus randomized table latencies and pass-through traffic against a behavioural model.
module tb_iguana_hyper_cfg_seq;

    localparam int NW  = 4;
    localparam int DLY = 16;
    localparam int TO  = 8;

    localparam logic [NW-1:0][47:0] CFG_ADDR = {48'h1234_5600_003C, 48'h1234_5600_0028,
                                                48'h1234_5600_0014, 48'h1234_5600_0010};
    localparam logic [NW-1:0][31:0] CFG_DATA = {32'hDEAD_0004, 32'h0BAD_0003,
                                                32'h5A5A_0002, 32'hA5A5_0001};

    logic        clk;
    logic        rst_n;
    logic        restart;
    logic        up_valid;
    logic        up_write;
    logic [47:0] up_addr;
    logic [31:0] up_wdata;
    logic [3:0]  up_wstrb;
    logic        up_ready;
    logic [31:0] up_rdata;
    logic        up_error;
    logic        dn_valid;
    logic        dn_write;
    logic [47:0] dn_addr;
    logic [31:0] dn_wdata;
    logic [3:0]  dn_wstrb;
    logic        dn_ready;
    logic [31:0] dn_rdata;
    logic        dn_error;
    logic        cfg_done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;
    bit model_err = 0;

    iguana_hyper_cfg_seq #(
        .NumWrites    (NW),
        .AddrWidth    (48),
        .DataWidth    (32),
        .CfgAddr      (CFG_ADDR),
        .CfgData      (CFG_DATA),
        .DelayCycles  (DLY),
        .TimeoutCycles(TO)
    ) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .restart_i (restart),
        .up_valid_i(up_valid),
        .up_write_i(up_write),
        .up_addr_i (up_addr),
        .up_wdata_i(up_wdata),
        .up_wstrb_i(up_wstrb),
        .up_ready_o(up_ready),
        .up_rdata_o(up_rdata),
        .up_error_o(up_error),
        .dn_valid_o(dn_valid),
        .dn_write_o(dn_write),
        .dn_addr_o (dn_addr),
        .dn_wdata_o(dn_wdata),
        .dn_wstrb_o(dn_wstrb),
        .dn_ready_i(dn_ready),
        .dn_rdata_i(dn_rdata),
        .dn_error_i(dn_error),
        .cfg_done_o(cfg_done),
        .cfg_err_o (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expects to be called on the negedge right after reset release or restart.
    task automatic wait_delay();
        for (int i = 0; i < DLY; i++) begin
            checks++;
            if ({dn_valid, up_ready, cfg_done} !== 3'b000) begin
                errors++;
                $display("FAIL delay_idle cycle %0d: valid/ready/done=%b want 000", i,
                         {dn_valid, up_ready, cfg_done});
            end
            @(negedge clk);
        end
        checks++;
        if (dn_valid !== 1'b1) begin
            errors++;
            $display("FAIL delay_rise: dn_valid=%b want 1 after %0d cycles", dn_valid, DLY);
        end
    endtask

    // Model: entry k sees ready after w[k] valid cycles; more than TO-2 waits means timeout
    // after TO-1 valid cycles followed by one idle cycle.
    task automatic drive_table(input int w [NW], input bit e [NW]);
        for (int k = 0; k < NW; k++) begin
            int vc;
            vc = (w[k] <= TO - 2) ? w[k] + 1 : TO - 1;
            for (int c = 0; c < vc; c++) begin
                checks++;
                if ({dn_valid, dn_write, dn_addr, dn_wdata, dn_wstrb} !==
                    {1'b1, 1'b1, CFG_ADDR[k], CFG_DATA[k], 4'hF}) begin
                    errors++;
                    $display("FAIL table_req entry %0d cycle %0d: v=%b w=%b a=%h d=%h s=%h want a=%h d=%h",
                             k, c, dn_valid, dn_write, dn_addr, dn_wdata, dn_wstrb,
                             CFG_ADDR[k], CFG_DATA[k]);
                end
                checks++;
                if ({up_ready, up_rdata, up_error} !== 34'h0) begin
                    errors++;
                    $display("FAIL up_stall entry %0d: ready=%b rdata=%h err=%b want all 0",
                             k, up_ready, up_rdata, up_error);
                end
                dn_ready = (c == w[k]);
                dn_error = (c == w[k]) && e[k];
                @(negedge clk);
            end
            dn_ready = 1'b0;
            dn_error = 1'b0;
            if (w[k] > TO - 2) begin
                model_err = 1'b1;
                checks++;
                if (dn_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_gap entry %0d: dn_valid=%b want 0", k, dn_valid);
                end
                @(negedge clk);
            end else if (e[k]) begin
                model_err = 1'b1;
            end
            checks++;
            if (cfg_err !== model_err) begin
                errors++;
                $display("FAIL cfg_err after entry %0d: got %b want %b", k, cfg_err, model_err);
            end
            checks++;
            if (cfg_done !== (k == NW - 1)) begin
                errors++;
                $display("FAIL cfg_done after entry %0d: got %b want %b", k, cfg_done, k == NW - 1);
            end
        end
    endtask

    task automatic do_restart();
        up_valid = 1'b0;
        restart  = 1'b1;
        @(negedge clk);
        restart  = 1'b0;
        checks++;
        if ({cfg_done, cfg_err} !== {1'b0, model_err}) begin
            errors++;
            $display("FAIL restart: done/err=%b want 0%b", {cfg_done, cfg_err}, model_err);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        up_valid = 1'b1;
        dn_ready = 1'b1;
        dn_error = 1'b1;
        dn_rdata = 32'h1357_9BDF;
        #1;
        checks++;
        if ({dn_valid, up_ready, up_rdata, up_error, cfg_done, cfg_err} !== 37'h0) begin
            errors++;
            $display("FAIL reset_state: dv=%b ur=%b rd=%h ue=%b done=%b err=%b want all 0",
                     dn_valid, up_ready, up_rdata, up_error, cfg_done, cfg_err);
        end
        up_valid = 1'b0;
        dn_ready = 1'b0;
        dn_error = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_err = 1'b0;
        wait_delay();
    endtask

    task automatic test_table_stall();
        up_valid = 1'b1;
        up_write = 1'b0;
        up_addr  = 48'h0;
        drive_table('{0, 3, 1, 5}, '{0, 0, 0, 0});
        checks++;
        if ({dn_valid, dn_write, dn_addr} !== {1'b1, 1'b0, 48'h0}) begin
            errors++;
            $display("FAIL stall_read_issue: v=%b w=%b a=%h want 1 0 0", dn_valid, dn_write, dn_addr);
        end
        dn_ready = 1'b1;
        dn_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({up_ready, up_rdata, up_error} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            errors++;
            $display("FAIL stall_read_resp: ready=%b rdata=%h err=%b want 1 cafef00d 0",
                     up_ready, up_rdata, up_error);
        end
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        dn_ready = 1'b0;
        #1;
        checks++;
        if (dn_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_read: dn_valid=%b want 0", dn_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_error();
        do_restart();
        wait_delay();
        drive_table('{1, 0, 2, 0}, '{0, 1, 0, 0});
    endtask

    task automatic test_timeout();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_err = 1'b0;
        wait_delay();
        drive_table('{9, 0, 0, 0}, '{0, 0, 0, 0});
    endtask

    task automatic test_reset_mid();
        do_restart();
        wait_delay();
        for (int k = 0; k < 2; k++) begin
            dn_ready = 1'b1;
            @(negedge clk);
        end
        dn_ready = 1'b0;
        checks++;
        if (dn_addr !== CFG_ADDR[2]) begin
            errors++;
            $display("FAIL mid_entry2: addr=%h want %h", dn_addr, CFG_ADDR[2]);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dn_valid, cfg_err, cfg_done} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: valid/err/done=%b want 000", {dn_valid, cfg_err, cfg_done});
        end
        model_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_delay();
        drive_table('{0, 0, 0, 0}, '{0, 0, 0, 0});
    endtask

    task automatic test_random_tables();
        for (int r = 0; r < 6; r++) begin
            int w [NW];
            bit e [NW];
            for (int k = 0; k < NW; k++) begin
                w[k] = int'($urandom_range(0, 9));
                e[k] = ($urandom_range(0, 3) == 0);
            end
            do_restart();
            wait_delay();
            drive_table(w, e);
        end
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 24; i++) begin
            up_valid = $urandom_range(0, 1) == 1;
            up_write = $urandom_range(0, 1) == 1;
            up_addr  = {$urandom(), $urandom()} >> 16;
            up_wdata = $urandom();
            up_wstrb = 4'($urandom());
            dn_ready = $urandom_range(0, 1) == 1;
            dn_rdata = $urandom();
            dn_error = $urandom_range(0, 1) == 1;
            restart  = up_valid && ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if ({dn_valid, dn_write, dn_addr, dn_wdata, dn_wstrb, up_ready, up_rdata, up_error} !==
                {up_valid, up_write, up_addr, up_wdata, up_wstrb, dn_ready, dn_rdata, dn_error}) begin
                errors++;
                $display("FAIL pass_map %0d: dn v=%b w=%b a=%h d=%h s=%h up r=%b d=%h e=%b", i,
                         dn_valid, dn_write, dn_addr, dn_wdata, dn_wstrb, up_ready, up_rdata, up_error);
            end
            @(negedge clk);
            checks++;
            if (cfg_done !== 1'b1) begin
                errors++;
                $display("FAIL pass_hold %0d: cfg_done=%b want 1", i, cfg_done);
            end
        end
        restart  = 1'b0;
        up_valid = 1'b0;
        dn_ready = 1'b0;
        dn_error = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        restart  = 1'b0;
        up_valid = 1'b0;
        up_write = 1'b0;
        up_addr  = '0;
        up_wdata = '0;
        up_wstrb = '0;
        dn_ready = 1'b0;
        dn_rdata = '0;
        dn_error = 1'b0;
        test_reset();
        test_table_stall();
        test_error();
        test_timeout();
        test_reset_mid();
        test_random_tables();
        test_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
